// File: rtl/reg_pkg.sv
// Shared register-file geometry, FSM encoding and stall-counter constants
// for the operand fetch unit and its scoreboard.
package reg_pkg;

  localparam int BITS_DATA  = 32;
  localparam int BITS_ADDR  = 3;
  localparam int NUM_REGS   = 1 << BITS_ADDR;
  localparam int STALL_BITS = 16;

  typedef logic [BITS_ADDR-1:0]  addr_t;
  typedef logic [BITS_DATA-1:0]  data_t;
  typedef logic [STALL_BITS-1:0] stall_t;

  localparam stall_t STALL_MAX = {STALL_BITS{1'b1}};
  localparam stall_t STALL_INC = {{(STALL_BITS-1){1'b0}}, 1'b1};

  // 2'd3 is never entered; the FSM recovers from it to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/operand_fetch_unit_if.sv
// Decoder, register-array, writeback and execute-side signals of the
// operand fetch unit; slave is the unit, master is its environment.
interface operand_fetch_unit_if import reg_pkg::*; ();

  logic   instValid;
  logic   instReady;
  addr_t  instSrc1;
  addr_t  instSrc2;
  addr_t  instDest;
  logic   instWritesDest;

  addr_t  rfAddr1;
  addr_t  rfAddr2;
  data_t  rfData1;
  data_t  rfData2;

  logic   wbValid;
  addr_t  wbAddr;

  logic   opValid;
  logic   opReady;
  data_t  opData1;
  data_t  opData2;
  addr_t  opDest;
  logic   opWritesDest;

  stall_t stallCount;

  modport slave (
    input  instValid, instSrc1, instSrc2, instDest, instWritesDest,
    input  rfData1, rfData2, wbValid, wbAddr, opReady,
    output instReady, rfAddr1, rfAddr2,
    output opValid, opData1, opData2, opDest, opWritesDest, stallCount
  );

  modport master (
    output instValid, instSrc1, instSrc2, instDest, instWritesDest,
    output rfData1, rfData2, wbValid, wbAddr, opReady,
    input  instReady, rfAddr1, rfAddr2,
    input  opValid, opData1, opData2, opDest, opWritesDest, stallCount
  );

endinterface

// File: rtl/operand_fetch_unit_scoreboard.sv
// Per-register busy bits: set at issue, cleared at writeback, set wins
// when both hit the same register in one cycle.
module operand_fetch_unit_scoreboard import reg_pkg::*; (
  input  logic  clk_i,
  input  logic  reset_i,
  input  logic  set_i,
  input  addr_t set_addr_i,
  input  logic  clr_i,
  input  addr_t clr_addr_i,
  input  addr_t rd_addr1_i,
  input  addr_t rd_addr2_i,
  output logic  busy1_o,
  output logic  busy2_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Next busy vector with the newer producer taking priority.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_d[i] = (set_i && (set_addr_i == addr_t'(i))) ? 1'b1 :
                  (clr_i && (clr_addr_i == addr_t'(i))) ? 1'b0 : busy_q[i];
    end
  end

  // Busy register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q <= {NUM_REGS{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy1_o = busy_q[rd_addr1_i];
  assign busy2_o = busy_q[rd_addr2_i];

endmodule

// File: rtl/operand_fetch_unit.sv
// Single-instruction operand fetch: latch sources, wait out RAW hazards on
// the scoreboard, capture register data and hold it until execute accepts.
module operand_fetch_unit import reg_pkg::*; (
  input logic           clk,
  input logic           reset,
  operand_fetch_unit_if.slave bus
);

  state_e state_q, state_d;
  addr_t  src1_q, src1_d;
  addr_t  src2_q, src2_d;
  addr_t  dest_q, dest_d;
  logic   wr_q, wr_d;
  data_t  op1_q, op1_d;
  data_t  op2_q, op2_d;
  stall_t stall_q, stall_d;

  logic   busy1_s;
  logic   busy2_s;
  logic   hazard_s;
  logic   sb_set_s;

  operand_fetch_unit_scoreboard u_scoreboard (
    .clk_i      (clk),
    .reset_i    (reset),
    .set_i      (sb_set_s),
    .set_addr_i (dest_q),
    .clr_i      (bus.wbValid),
    .clr_addr_i (bus.wbAddr),
    .rd_addr1_i (src1_q),
    .rd_addr2_i (src2_q),
    .busy1_o    (busy1_s),
    .busy2_o    (busy2_s)
  );

  // Equal sources look up the same bit, so this is a single check for them.
  assign hazard_s = busy1_s | busy2_s;

  // Next-state, operand capture, stall counting and issue marking.
  always_comb begin
    state_d  = state_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    dest_d   = dest_q;
    wr_d     = wr_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    stall_d  = stall_q;
    sb_set_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.instValid) begin
          src1_d  = bus.instSrc1;
          src2_d  = bus.instSrc2;
          dest_d  = bus.instDest;
          wr_d    = bus.instWritesDest;
          state_d = READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (hazard_s) begin
          stall_d = (stall_q == STALL_MAX) ? stall_q : stall_q + STALL_INC;
          state_d = READ;
        end else begin
          op1_d   = bus.rfData1;
          op2_d   = bus.rfData2;
          state_d = OUT;
        end
      end
      OUT: begin
        if (bus.opReady) begin
          sb_set_s = wr_q;
          state_d  = IDLE;
        end else begin
          state_d  = OUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src1_q  <= {BITS_ADDR{1'b0}};
      src2_q  <= {BITS_ADDR{1'b0}};
      dest_q  <= {BITS_ADDR{1'b0}};
      wr_q    <= 1'b0;
      op1_q   <= {BITS_DATA{1'b0}};
      op2_q   <= {BITS_DATA{1'b0}};
      stall_q <= {STALL_BITS{1'b0}};
    end else begin
      state_q <= state_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      dest_q  <= dest_d;
      wr_q    <= wr_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      stall_q <= stall_d;
    end
  end

  assign bus.instReady    = (state_q == IDLE);
  assign bus.opValid      = (state_q == OUT);
  assign bus.rfAddr1      = src1_q;
  assign bus.rfAddr2      = src2_q;
  assign bus.opData1      = op1_q;
  assign bus.opData2      = op2_q;
  assign bus.opDest       = dest_q;
  assign bus.opWritesDest = wr_q;
  assign bus.stallCount   = stall_q;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Bench for operand_fetch_unit: vector table, directed hazard sequences and
// a randomized phase checked against a pending-writer model.
module tb_operand_fetch_unit;

  logic clk;
  logic reset;
  logic [31:0] wbData;
  logic [31:0] regs [8];
  int tests = 0;
  int fails = 0;

  operand_fetch_unit_if bus ();

  operand_fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register array model: combinational read, write at the writeback edge.
  always @(posedge clk) begin
    if (bus.wbValid) regs[bus.wbAddr] <= wbData;
  end
  assign bus.rfData1 = regs[bus.rfAddr1];
  assign bus.rfData2 = regs[bus.rfAddr2];

  typedef struct {
    logic [2:0]  s1;
    logic [2:0]  s2;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  typedef struct packed {
    logic [2:0] s1;
    logic [2:0] s2;
    logic [2:0] d;
    logic       w;
  } inst_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
    bus.wbValid = 1'b1;
    bus.wbAddr  = a;
    wbData      = d;
    tick();
    bus.wbValid = 1'b0;
  endtask

  task automatic issue(input logic [2:0] s1, input logic [2:0] s2,
                       input logic [2:0] d, input logic w);
    int n = 0;
    while (bus.instReady !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("issue_ready_timeout", 32'(bus.instReady), 32'd1);
    bus.instSrc1       = s1;
    bus.instSrc2       = s2;
    bus.instDest       = d;
    bus.instWritesDest = w;
    bus.instValid      = 1'b1;
    tick();
    bus.instValid      = 1'b0;
  endtask

  task automatic wait_op(input int budget, output int lat);
    lat = 1;
    while (bus.opValid !== 1'b1 && lat < budget) begin
      tick();
      lat++;
    end
    if (bus.opValid !== 1'b1) chk("op_valid_timeout", 32'(bus.opValid), 32'd1);
  endtask

  task automatic handshake();
    bus.opReady = 1'b1;
    tick();
    bus.opReady = 1'b0;
  endtask

  vec_t vecs [4];
  int lat;
  logic [15:0] s0;
  inst_t cur;
  logic have_cur;
  logic [7:0] pend;
  int issued, done, cyc;
  logic [2:0] r;

  initial begin
    vecs[0] = '{3'd2, 3'd5, 32'h11,       32'h22,       32'h11,       32'h22};
    vecs[1] = '{3'd4, 3'd4, 32'h33,       32'h44,       32'h44,       32'h44};
    vecs[2] = '{3'd0, 3'd7, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
    vecs[3] = '{3'd7, 3'd0, 32'hFFFFFFFF, 32'h80000001, 32'hFFFFFFFF, 32'h80000001};

    reset = 1'b1;
    bus.instValid = 1'b0; bus.instSrc1 = 3'd0; bus.instSrc2 = 3'd0;
    bus.instDest = 3'd0; bus.instWritesDest = 1'b0;
    bus.wbValid = 1'b0; bus.wbAddr = 3'd0; wbData = 32'd0; bus.opReady = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    chk("rst_instReady", 32'(bus.instReady), 32'd1);
    chk("rst_opValid", 32'(bus.opValid), 32'd0);
    chk("rst_stall", 32'(bus.stallCount), 32'd0);
    chk("rst_opData1", bus.opData1, 32'd0);
    chk("rst_opData2", bus.opData2, 32'd0);
    chk("rst_opDest", 32'(bus.opDest), 32'd0);
    chk("rst_opWr", 32'(bus.opWritesDest), 32'd0);
    chk("rst_rfAddr1", 32'(bus.rfAddr1), 32'd0);
    chk("rst_rfAddr2", 32'(bus.rfAddr2), 32'd0);

    for (int i = 0; i < 8; i++) wb_write(3'(i), 32'h100 + 32'(i));

    for (int i = 0; i < 4; i++) begin
      wb_write(vecs[i].s1, vecs[i].v1);
      wb_write(vecs[i].s2, vecs[i].v2);
      issue(vecs[i].s1, vecs[i].s2, 3'd1, 1'b0);
      wait_op(20, lat);
      chk("vec_latency", 32'(lat), 32'd2);
      chk("vec_opData1", bus.opData1, vecs[i].e1);
      chk("vec_opData2", bus.opData2, vecs[i].e2);
      chk("vec_opDest", 32'(bus.opDest), 32'd1);
      chk("vec_opWr", 32'(bus.opWritesDest), 32'd0);
      handshake();
    end

    // RAW hazard on R3 released by a writeback.
    issue(3'd0, 3'd0, 3'd3, 1'b1);
    wait_op(20, lat);
    handshake();
    issue(3'd3, 3'd1, 3'd0, 1'b0);
    s0 = bus.stallCount;
    repeat (4) tick();
    chk("haz_stall_count", 32'(bus.stallCount), 32'(s0) + 32'd4);
    chk("haz_opValid", 32'(bus.opValid), 32'd0);
    chk("haz_instReady", 32'(bus.instReady), 32'd0);
    wb_write(3'd3, 32'hABCD);
    wait_op(20, lat);
    chk("haz_release_latency", 32'(lat), 32'd2);
    chk("haz_opData1", bus.opData1, 32'hABCD);
    chk("haz_opData2", bus.opData2, 32'h101);
    handshake();

    // Backpressure in OUT; a writeback to the dest before the handshake must not pre-clear it.
    wb_write(3'd1, 32'h5151);
    wb_write(3'd2, 32'h5252);
    issue(3'd1, 3'd2, 3'd6, 1'b1);
    wait_op(20, lat);
    for (int k = 0; k < 5; k++) begin
      chk("hold_opValid", 32'(bus.opValid), 32'd1);
      chk("hold_opData1", bus.opData1, 32'h5151);
      chk("hold_opData2", bus.opData2, 32'h5252);
      chk("hold_instReady", 32'(bus.instReady), 32'd0);
      chk("hold_opDest", 32'(bus.opDest), 32'd6);
      bus.wbValid = (k == 2);
      bus.wbAddr  = 3'd6;
      wbData      = 32'h6666;
      tick();
    end
    bus.wbValid = 1'b0;
    handshake();
    issue(3'd6, 3'd6, 3'd0, 1'b0);
    repeat (3) tick();
    chk("hold_busy_after_hs", 32'(bus.opValid), 32'd0);
    wb_write(3'd6, 32'h6767);
    wait_op(20, lat);
    chk("hold_rel_opData1", bus.opData1, 32'h6767);
    chk("hold_rel_opData2", bus.opData2, 32'h6767);
    handshake();

    // Set and clear of busy[4] in the same cycle.
    issue(3'd0, 3'd0, 3'd4, 1'b1);
    wait_op(20, lat);
    handshake();
    issue(3'd0, 3'd0, 3'd4, 1'b1);
    wait_op(20, lat);
    bus.opReady = 1'b1;
    bus.wbValid = 1'b1; bus.wbAddr = 3'd4; wbData = 32'h4444;
    tick();
    bus.opReady = 1'b0;
    bus.wbValid = 1'b0;
    issue(3'd4, 3'd0, 3'd0, 1'b0);
    repeat (3) tick();
    chk("setwins_stalled", 32'(bus.opValid), 32'd0);
    wb_write(3'd4, 32'h4545);
    wait_op(20, lat);
    chk("setwins_latency", 32'(lat), 32'd2);
    chk("setwins_opData1", bus.opData1, 32'h4545);
    handshake();

    // Stall counter saturation.
    issue(3'd0, 3'd0, 3'd5, 1'b1);
    wait_op(20, lat);
    handshake();
    issue(3'd5, 3'd5, 3'd0, 1'b0);
    repeat (65539) tick();
    chk("sat_stall", 32'(bus.stallCount), 32'h0000FFFF);
    chk("sat_opValid", 32'(bus.opValid), 32'd0);

    // Reset while stalled.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_opValid", 32'(bus.opValid), 32'd0);
    chk("midrst_instReady", 32'(bus.instReady), 32'd1);
    chk("midrst_stall", 32'(bus.stallCount), 32'd0);
    chk("midrst_rfAddr1", 32'(bus.rfAddr1), 32'd0);
    issue(3'd5, 3'd5, 3'd0, 1'b0);
    wait_op(20, lat);
    chk("midrst_no_stall_latency", 32'(lat), 32'd2);
    chk("midrst_opData1", bus.opData1, 32'h22);
    handshake();

    // Randomized traffic against a pending-writer model.
    pend = 8'd0; have_cur = 1'b0; issued = 0; done = 0; cyc = 0;
    cur = '0;
    while (done < 300 && cyc < 30000) begin
      bus.wbValid = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        r = 3'($urandom_range(0, 7));
        for (int k = 0; k < 8; k++) begin
          if (!bus.wbValid && pend[r + 3'(k)]) begin
            bus.wbValid = 1'b1;
            bus.wbAddr  = r + 3'(k);
            wbData      = $urandom;
          end
        end
      end
      bus.opReady = ($urandom_range(0, 9) < 7);
      if (bus.opValid && bus.opReady) begin
        chk("rnd_read_while_busy", 32'(pend[cur.s1] | pend[cur.s2]), 32'd0);
        chk("rnd_opData1", bus.opData1, regs[cur.s1]);
        chk("rnd_opData2", bus.opData2, regs[cur.s2]);
        chk("rnd_opDest", 32'(bus.opDest), 32'(cur.d));
        chk("rnd_opWr", 32'(bus.opWritesDest), 32'(cur.w));
      end
      if (bus.wbValid) pend[bus.wbAddr] = 1'b0;
      if (bus.opValid && bus.opReady) begin
        if (cur.w) pend[cur.d] = 1'b1;
        have_cur = 1'b0;
        done++;
      end
      bus.instValid = 1'b0;
      if (bus.instReady && !have_cur && issued < 300) begin
        cur.s1 = 3'($urandom_range(0, 7));
        cur.s2 = ($urandom_range(0, 4) == 0) ? cur.s1 : 3'($urandom_range(0, 7));
        cur.d  = 3'($urandom_range(0, 7));
        cur.w  = ($urandom_range(0, 1) == 1) && !pend[cur.d];
        bus.instSrc1 = cur.s1; bus.instSrc2 = cur.s2;
        bus.instDest = cur.d;  bus.instWritesDest = cur.w;
        bus.instValid = 1'b1;
        have_cur = 1'b1;
        issued++;
      end
      tick();
      cyc++;
    end
    bus.instValid = 1'b0;
    bus.opReady   = 1'b0;
    bus.wbValid   = 1'b0;
    chk("rnd_completed", 32'(done), 32'd300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
